// File: rtl/contrast_curve_engine.sv
`default_nettype none
// ============================================================================
//  Module   : contrast_curve_engine
//  Purpose  : Multi-channel pipelined contrast/gamma curve engine. Each channel
//             owns a writable table of 2^LUT_DEPTH+1 knots, pre-loaded with a
//             power-law curve. A sample selects a knot pair by its upper bits
//             and is linearly interpolated with its lower bits. Three pipeline
//             stages, one sample per cycle, valid/ready with backpressure,
//             per-channel bypass.
//  Ports    : clk_peri, reset_n       - clock, async active-low reset
//             in_valid/in_ready       - input handshake
//             in_data, in_chan        - sample and channel select
//             out_valid/out_ready     - output handshake
//             out_data, out_chan      - curved sample and its channel
//             cfg_we/chan/addr/data   - knot write port (one knot per cycle)
//             cfg_bypass              - per-channel bypass, sampled on accept
//  Revision : 1.0  initial release
// ============================================================================
module contrast_curve_engine #(
  parameter int DATA_WIDTH = 10,
  parameter int LUT_DEPTH  = 6,
  parameter int CHANNELS   = 3,
  parameter int EXPONENT   = 3,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk_peri,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CW-1:0]         in_chan,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]         out_chan,
  input  logic                  cfg_we,
  input  logic [CW-1:0]         cfg_chan,
  input  logic [LUT_DEPTH:0]    cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_data,
  input  logic [CHANNELS-1:0]   cfg_bypass
);

  localparam int C_FRAC   = DATA_WIDTH - LUT_DEPTH;
  localparam int C_FW     = (C_FRAC > 0) ? C_FRAC : 1;
  localparam int C_NKNOTS = (2 ** LUT_DEPTH) + 1;
  localparam int C_PW     = DATA_WIDTH + C_FW + 2;
  localparam longint unsigned C_MAXV = (64'd1 << DATA_WIDTH) - 64'd1;
  localparam logic [CW:0]        C_CHANS     = (CW+1)'(CHANNELS);
  localparam logic [LUT_DEPTH:0] C_LAST_ADDR = (LUT_DEPTH+1)'(2 ** LUT_DEPTH);

  typedef logic [DATA_WIDTH-1:0] table_t [CHANNELS][C_NKNOTS];

  // Power-law start curve: knot k = min(max, (k*2^FRAC)^EXP / 2^(DW*(EXP-1))).
  // 64-bit arithmetic keeps the intermediate power exact.
  function automatic table_t f_init_tables();
    table_t          t;
    longint unsigned x;
    longint unsigned p;
    for (int k = 0; k < C_NKNOTS; k++) begin
      x = 64'(k) << C_FRAC;
      p = 64'd1;
      for (int e = 0; e < EXPONENT; e++) p = p * x;
      p = p >> (DATA_WIDTH * (EXPONENT - 1));
      if (p > C_MAXV) p = C_MAXV;
      for (int c = 0; c < CHANNELS; c++) t[c][k] = p[DATA_WIDTH-1:0];
    end
    return t;
  endfunction

  // Table contents are power-up configuration, not reset state: reset_n never
  // touches them, so runtime reloads survive a pipeline flush.
  table_t r_table = f_init_tables();

  logic w_cfg_ok;
  assign w_cfg_ok = cfg_we && ({1'b0, cfg_chan} < C_CHANS) && (cfg_addr <= C_LAST_ADDR);

  always_ff @(posedge clk_peri) begin
    if (w_cfg_ok) r_table[cfg_chan][cfg_addr] <= cfg_data;
  end

  // ---------------- handshake ----------------
  logic w_stall;
  logic w_accept;
  logic [CW-1:0] w_tchan;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_accept = in_valid & in_ready;
  // Out-of-range channels use table 0 but keep their raw id for out_chan.
  assign w_tchan  = ({1'b0, in_chan} < C_CHANS) ? in_chan : '0;

  // ---------------- stage registers ----------------
  logic                  r1_valid, r2_valid;
  logic [DATA_WIDTH-1:0] r1_data,  r2_data;
  logic [CW-1:0]         r1_chan,  r2_chan;
  logic [CW-1:0]         r1_tchan;
  logic                  r1_bypass, r2_bypass;
  logic [C_FW-1:0]       r2_frac;
  logic [DATA_WIDTH-1:0] r2_y0, r2_y1;

  logic [LUT_DEPTH-1:0]  w1_idx;
  logic [C_FW-1:0]       w1_frac;
  logic [LUT_DEPTH:0]    w1_addr0, w1_addr1;

  assign w1_idx   = r1_data[DATA_WIDTH-1:C_FRAC];
  assign w1_addr0 = {1'b0, w1_idx};
  assign w1_addr1 = w1_addr0 + 1'b1;

  generate
    if (C_FRAC > 0) begin : g_frac
      assign w1_frac = r1_data[C_FW-1:0];
    end else begin : g_nofrac
      assign w1_frac = '0;
    end
  endgenerate

  // ---------------- interpolation ----------------
  // d = y1 - y0 is signed; the arithmetic shift floors negative slopes.
  logic signed [DATA_WIDTH:0] w_diff;
  logic signed [C_PW-1:0]     w_prod;
  logic signed [C_PW-1:0]     w_step;
  logic [DATA_WIDTH-1:0]      w_result;
  logic                       w_unused;

  assign w_diff   = $signed({1'b0, r2_y1}) - $signed({1'b0, r2_y0});
  assign w_prod   = C_PW'(w_diff) * C_PW'($signed({1'b0, r2_frac}));
  assign w_step   = w_prod >>> C_FRAC;
  // Only the low DW bits matter: in-range knots keep the sum in range.
  assign w_result = r2_bypass ? r2_data : (r2_y0 + w_step[DATA_WIDTH-1:0]);
  assign w_unused = ^w_step[C_PW-1:DATA_WIDTH];

  // Every stage holds while the output is stalled; a sample past S2 keeps
  // the knot values it already read.
  always_ff @(posedge clk_peri or negedge reset_n) begin
    if (!reset_n) begin
      r1_valid  <= 1'b0;
      r1_data   <= '0;
      r1_chan   <= '0;
      r1_tchan  <= '0;
      r1_bypass <= 1'b0;
      r2_valid  <= 1'b0;
      r2_data   <= '0;
      r2_chan   <= '0;
      r2_bypass <= 1'b0;
      r2_frac   <= '0;
      r2_y0     <= '0;
      r2_y1     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (!w_stall) begin
      r1_valid <= w_accept;
      if (w_accept) begin
        r1_data   <= in_data;
        r1_chan   <= in_chan;
        r1_tchan  <= w_tchan;
        r1_bypass <= cfg_bypass[w_tchan];
      end
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_data   <= r1_data;
        r2_chan   <= r1_chan;
        r2_bypass <= r1_bypass;
        r2_frac   <= w1_frac;
        r2_y0     <= r_table[r1_tchan][w1_addr0];
        r2_y1     <= r_table[r1_tchan][w1_addr1];
      end
      out_valid <= r2_valid;
      if (r2_valid) begin
        out_data <= w_result;
        out_chan <= r2_chan;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_contrast_curve_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_contrast_curve_engine
//  Purpose  : Directed stimulus with hand-computed expectations; expected
//             results are queued on acceptance and popped by an independent
//             output monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_contrast_curve_engine;

  logic       clk_peri = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_data;
  logic [1:0] in_chan;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [1:0] out_chan;
  logic       cfg_we;
  logic [1:0] cfg_chan;
  logic [6:0] cfg_addr;
  logic [9:0] cfg_data;
  logic [2:0] cfg_bypass;

  always #5 clk_peri = ~clk_peri;

  contrast_curve_engine dut (
    .clk_peri   (clk_peri),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_chan    (in_chan),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .cfg_we     (cfg_we),
    .cfg_chan   (cfg_chan),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_bypass (cfg_bypass)
  );

  typedef struct packed {
    logic [9:0] d;
    logic [1:0] c;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   acc_cyc = -1;
  int   first_out_cyc = -1;

  always @(posedge clk_peri) cyc <= cyc + 1;

  // Output monitor: a transfer happens at the next rising edge whenever
  // out_valid & out_ready are seen here.
  always @(negedge clk_peri) begin : monitor
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output: got data=%0d chan=%0d, required no output",
                 out_data, out_chan);
      end else begin
        e = sb.pop_front();
        if (out_data == e.d && out_chan == e.c) passes++;
        else $display("FAIL output: got data=%0d chan=%0d, required data=%0d chan=%0d",
                      out_data, out_chan, e.d, e.c);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  task automatic send(input logic [9:0] d, input logic [1:0] c, input logic [9:0] e);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_chan  = c;
    n = 0;
    @(negedge clk_peri);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk_peri);
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required 1");
    end else begin
      sb.push_back(exp_t'({e, c}));
      if (acc_cyc < 0) acc_cyc = cyc;
    end
    @(posedge clk_peri);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      n++;
      @(negedge clk_peri);
    end
    check("drain_pending", sb.size(), 0);
    @(posedge clk_peri);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] c, input logic [6:0] a, input logic [9:0] d);
    cfg_we   = 1'b1;
    cfg_chan = c;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk_peri);
    #1;
    cfg_we = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_chan    = '0;
    out_ready  = 1'b1;
    cfg_we     = 1'b0;
    cfg_chan   = '0;
    cfg_addr   = '0;
    cfg_data   = '0;
    cfg_bypass = '0;
    repeat (3) @(posedge clk_peri);
    #1 reset_n = 1'b1;
    @(negedge clk_peri);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_chan", int'(out_chan), 0);
    check("reset_in_ready", int'(in_ready), 1);
    @(posedge clk_peri);
    #1;

    // Default curve, back-to-back
    send(10'd0,    2'd0, 10'd0);
    send(10'd512,  2'd0, 10'd128);
    send(10'd520,  2'd0, 10'd134);
    send(10'd1023, 2'd0, 10'd1020);
    idle();
    drain();
    check("latency", first_out_cyc - acc_cyc, 3);

    // Independent tables; out-of-range writes and channels
    cfg_write(2'd1, 7'd32, 10'd600);
    cfg_write(2'd3, 7'd32, 10'd5);
    send(10'd512, 2'd1, 10'd600);
    send(10'd520, 2'd1, 10'd370);
    send(10'd512, 2'd0, 10'd128);
    send(10'd512, 2'd3, 10'd128);
    idle();
    drain();

    // Bypass sampled at acceptance
    cfg_bypass = 3'b100;
    send(10'd777, 2'd2, 10'd777);
    send(10'd777, 2'd0, 10'd447);
    send(10'd777, 2'd1, 10'd447);
    cfg_bypass = 3'b000;
    send(10'd777, 2'd2, 10'd447);
    idle();
    drain();

    // Backpressure
    out_ready = 1'b0;
    fork
      begin
        send(10'd520,  2'd0, 10'd134);
        send(10'd1023, 2'd0, 10'd1020);
        send(10'd512,  2'd0, 10'd128);
        send(10'd0,    2'd0, 10'd0);
        idle();
      end
      begin
        int n;
        n = 0;
        @(negedge clk_peri);
        while (!out_valid && n < 20) begin
          n++;
          @(negedge clk_peri);
        end
        check("stall_queued", sb.size(), 3);
        for (int i = 0; i < 5; i++) begin
          check("stall_in_ready", int'(in_ready), 0);
          check("stall_out_valid", int'(out_valid), 1);
          check("stall_out_data", int'(out_data), 134);
          @(negedge clk_peri);
        end
        @(posedge clk_peri);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Write/read collision on knot 32 of channel 0
    send(10'd512, 2'd0, 10'd128);
    cfg_we   = 1'b1;
    cfg_chan = 2'd0;
    cfg_addr = 7'd32;
    cfg_data = 10'd300;
    send(10'd512, 2'd0, 10'd300);
    cfg_we = 1'b0;
    send(10'd520, 2'd0, 10'd220);
    idle();
    drain();
    cfg_write(2'd0, 7'd32, 10'd128);

    // Reset mid-stream with a stalled result at the output
    out_ready = 1'b0;
    send(10'd520, 2'd1, 10'd370);
    send(10'd512, 2'd0, 10'd128);
    send(10'd0,   2'd0, 10'd0);
    idle();
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        n++;
        @(negedge clk_peri);
      end
    end
    check("pre_reset_out_chan", int'(out_chan), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_out_valid", int'(out_valid), 0);
    check("async_reset_out_data", int'(out_data), 0);
    check("async_reset_out_chan", int'(out_chan), 0);
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk_peri);
    #1 reset_n = 1'b1;
    @(negedge clk_peri);
    check("post_reset_in_ready", int'(in_ready), 1);
    check("post_reset_out_valid", int'(out_valid), 0);
    @(posedge clk_peri);
    #1;
    send(10'd512, 2'd0, 10'd128);
    send(10'd512, 2'd1, 10'd600);
    idle();
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
